// File: rtl/gol_pkg.sv
// Shared board geometry, sequencer state encoding and write-source codes
// for the Conway generation sequencer.
package gol_pkg;

    localparam int unsigned MAX_X = 32;
    localparam int unsigned MAX_Y = 24;
    localparam int unsigned PAT_H = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SWAP,
        ST_CLEAR,
        ST_STAMP
    } state_e;

    typedef enum logic [1:0] {
        WR_NEXT = 2'd0,
        WR_ZERO = 2'd1,
        WR_PAT  = 2'd2
    } wr_sel_e;

endpackage

// File: rtl/wrap_counter.sv
// Loadable row counter that wraps at MODULO using compare-and-wrap.
module wrap_counter #(
    parameter int unsigned MODULO = 24,
    parameter int unsigned W      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (inc_i)
            cnt_d = (cnt_q == W'(MODULO - 1)) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gen_sequencer.sv
// Sequences generation step, pattern stamp and board clear over one shared
// cell-RAM port; live buffer is read, shadow written, then swapped.
module gen_sequencer #(
    parameter int unsigned MAX_Y = gol_pkg::MAX_Y,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned PAT_H = gol_pkg::PAT_H,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             freeze,
    input  logic             draw_req,
    input  logic             clear_req,
    input  logic [ROW_W-1:0] cursor_y,
    output logic             rd_en,
    output logic [ROW_W-1:0] rd_row,
    output logic             win_shift,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic             wr_live,
    output logic [1:0]       wr_sel,
    output logic [2:0]       pat_line,
    output logic             swap,
    output logic             draw_ack,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             tick_missed
);

    import gol_pkg::*;

    localparam int unsigned PH_W = $clog2(MAX_Y + 5);

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             pend_q, pend_d;
    logic             missed_q, missed_d;
    logic             step_go, last_clear, enter;
    logic [ROW_W-1:0] rd_ld_val, wr_ld_val, rd_cnt, wr_cnt;
    wr_sel_e          sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            gen_q    <= '0;
            pend_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            gen_q    <= gen_d;
            pend_q   <= pend_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_go = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req || pend_q)
                    state_d = ST_CLEAR;
                else if (draw_req)
                    state_d = ST_STAMP;
                else if (tick && !freeze) begin
                    state_d = ST_STEP;
                    step_go = 1'b1;
                end
            end
            ST_STEP:  if (phase_q == PH_W'(MAX_Y + 3)) state_d = ST_SWAP;
            ST_SWAP:  state_d = ST_IDLE;
            ST_CLEAR: if (phase_q == PH_W'(MAX_Y - 1)) state_d = ST_IDLE;
            ST_STAMP: if (phase_q == PH_W'(PAT_H)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        phase_d    = (state_d != state_q) ? '0 : phase_q + PH_W'(1);
        last_clear = (state_q == ST_CLEAR) && (state_d == ST_IDLE);

        gen_d = gen_q;
        if (last_clear)
            gen_d = '0;
        else if (state_q == ST_SWAP)
            gen_d = gen_q + GEN_W'(1);

        // A clear arriving in the final clear cycle must still be honoured.
        pend_d = pend_q;
        if (clear_req && state_q != ST_IDLE)
            pend_d = 1'b1;
        else if (last_clear)
            pend_d = 1'b0;

        missed_d = missed_q | (tick & ~freeze & ~step_go);

        enter     = (state_q == ST_IDLE) && (state_d != ST_IDLE);
        rd_ld_val = (state_d == ST_STAMP) ? cursor_y : ROW_W'(MAX_Y - 1);
        wr_ld_val = (state_d == ST_STAMP) ? cursor_y : '0;
    end

    always_comb begin
        rd_en     = 1'b0;
        win_shift = 1'b0;
        wr_en     = 1'b0;
        wr_live   = 1'b0;
        sel       = WR_NEXT;
        pat_line  = '0;
        swap      = 1'b0;
        draw_ack  = 1'b0;
        unique case (state_q)
            ST_STEP: begin
                rd_en     = (phase_q <= PH_W'(MAX_Y + 1));
                win_shift = (phase_q >= PH_W'(1)) && (phase_q <= PH_W'(MAX_Y + 2));
                wr_en     = (phase_q >= PH_W'(4));
            end
            ST_SWAP: swap = 1'b1;
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_live = 1'b1;
                sel     = WR_ZERO;
            end
            ST_STAMP: begin
                rd_en    = (phase_q < PH_W'(PAT_H));
                wr_en    = (phase_q != '0);
                draw_ack = (phase_q == PH_W'(PAT_H));
                if (wr_en) begin
                    wr_live  = 1'b1;
                    sel      = WR_PAT;
                    pat_line = 3'(phase_q - PH_W'(1));
                end
            end
            default: ;
        endcase
    end

    wrap_counter #(.MODULO(MAX_Y), .W(ROW_W)) u_rd_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (enter),
        .load_val_i (rd_ld_val),
        .inc_i      (rd_en),
        .cnt_o      (rd_cnt)
    );

    wrap_counter #(.MODULO(MAX_Y), .W(ROW_W)) u_wr_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (enter),
        .load_val_i (wr_ld_val),
        .inc_i      (wr_en),
        .cnt_o      (wr_cnt)
    );

    assign rd_row      = rd_en ? rd_cnt : '0;
    assign wr_row      = wr_en ? wr_cnt : '0;
    assign wr_sel      = sel;
    assign busy        = (state_q != ST_IDLE);
    assign gen_count   = gen_q;
    assign tick_missed = missed_q;

endmodule
